// File: rtl/piped_adder_pkg.sv
// Shared constants and types for piped_adder and its request arbiter.
// No logic: widths, FSM encodings and the ceil-log2 helper only.
package piped_adder_pkg;

  function automatic int CEIL_LOG2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

  // One extra sum bit per level of the adder tree.
  function automatic int calc_out_w(input int n_args, input int arg_width);
    return arg_width + CEIL_LOG2(n_args);
  endfunction

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_DRAINED = 2'd2
  } arb_state_t;

endpackage

// File: rtl/piped_adder_arb_if.sv
// Requester, adder and control-plane signals of piped_adder_arb.
// master = requesters + adder + control plane, slave = the arbiter.
interface piped_adder_arb_if #(
  parameter int N_REQ     = 4,
  parameter int N_args    = 8,
  parameter int arg_width = 12
);
  localparam int OUT_W = piped_adder_pkg::calc_out_w(N_args, arg_width);

  logic [N_REQ-1:0]                 req_valid;
  logic [N_REQ-1:0]                 req_ready;
  logic [N_REQ*N_args*arg_width-1:0] req_args;
  logic [N_args*arg_width-1:0]      adder_args;
  logic                             adder_we;
  logic [OUT_W-1:0]                 adder_sum;
  logic                             adder_valid;
  logic [N_REQ-1:0]                 resp_valid;
  logic [OUT_W-1:0]                 resp_sum;
  logic                             drain_req;
  logic                             drained;
  logic                             err;

  modport master (
    output req_valid, req_args, adder_sum, adder_valid, drain_req,
    input  req_ready, adder_args, adder_we, resp_valid, resp_sum, drained, err
  );

  modport slave (
    input  req_valid, req_args, adder_sum, adder_valid, drain_req,
    output req_ready, adder_args, adder_we, resp_valid, resp_sum, drained, err
  );
endinterface

// File: rtl/piped_adder_tag_pipe.sv
// Delay line for {valid, tag}; DEPTH clocks, plain wire when DEPTH is 0.
// Latency: DEPTH. Backpressure: none, shifts every clock.
module piped_adder_tag_pipe #(
  parameter int DEPTH = 3,
  parameter int W     = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_vld,
  input  logic [W-1:0] in_dat,
  output logic         out_vld,
  output logic [W-1:0] out_dat
);
  generate
    if (DEPTH == 0) begin : g_wire
      assign out_vld = in_vld;
      assign out_dat = in_dat;
    end else begin : g_sr
      logic [DEPTH-1:0] vld_q;
      logic [W-1:0]     dat_q [DEPTH];

      always_ff @(posedge clk) begin
        if (reset) begin
          vld_q <= '0;
          for (int i = 0; i < DEPTH; i++) dat_q[i] <= '0;
        end else begin
          vld_q[0] <= in_vld;
          dat_q[0] <= in_dat;
          for (int i = 1; i < DEPTH; i++) begin
            vld_q[i] <= vld_q[i-1];
            dat_q[i] <= dat_q[i-1];
          end
        end
      end

      assign out_vld = vld_q[DEPTH-1];
      assign out_dat = dat_q[DEPTH-1];
    end
  endgenerate
endmodule

// File: rtl/piped_adder_arb.sv
// Shares one piped_adder among N_REQ requesters; round-robin with PIPED_ADDER_ARB_RR_EN, else fixed priority.
// Latency: grant to resp_valid is LAT+2 clocks, one request per clock sustained.
// Backpressure: none from adder or response side; req_ready is gated only by the drain FSM.
module piped_adder_arb
  import piped_adder_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int N_args    = 8,
  parameter int arg_width = 12
) (
  input logic              clk,
  input logic              reset,
  piped_adder_arb_if.slave bus
);
  localparam int LAT    = CEIL_LOG2(N_args);
  localparam int ARGS_W = N_args * arg_width;
  localparam int ID_W   = CEIL_LOG2(N_REQ);
  localparam int CNT_W  = CEIL_LOG2(LAT + 2);

  arb_state_t        state;
  logic [N_REQ-1:0]  gnt;
  logic [ID_W-1:0]   win;
  logic [ARGS_W-1:0] win_args;
  logic              xfer;
  logic              ret;
  logic [ID_W-1:0]   launch_id;
  logic              tag_vld;
  logic [ID_W-1:0]   tag_id;
  logic [CNT_W-1:0]  outst;
  logic [CNT_W-1:0]  mask_cnt;

`ifdef PIPED_ADDER_ARB_RR_EN
  logic [ID_W-1:0] ptr;

  // Scan from the farthest offset down so the first valid at or after ptr wins.
  always_comb begin
    logic [ID_W-1:0] idx;
    idx = '0;
    gnt = '0;
    win = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = ID_W'((int'(ptr) + i) % N_REQ);
      if (bus.req_valid[idx]) begin
        gnt = N_REQ'(1) << idx;
        win = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (xfer) begin
      ptr <= (int'(win) == N_REQ - 1) ? '0 : win + 1'b1;
    end
  end
`else
  always_comb begin
    gnt = '0;
    win = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        gnt = N_REQ'(1) << i;
        win = ID_W'(i);
      end
    end
  end
`endif

  assign bus.req_ready = (state == ST_RUN && !reset) ? gnt : '0;
  assign xfer          = |bus.req_ready;
  assign ret           = bus.adder_valid & tag_vld;

  always_comb begin
    win_args = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (win == ID_W'(k)) win_args = bus.req_args[k*ARGS_W +: ARGS_W];
    end
  end

  piped_adder_tag_pipe #(
    .DEPTH (LAT),
    .W     (ID_W)
  ) u_tag_pipe (
    .clk     (clk),
    .reset   (reset),
    .in_vld  (bus.adder_we),
    .in_dat  (launch_id),
    .out_vld (tag_vld),
    .out_dat (tag_id)
  );

  // mask_cnt hides adder_valid pulses still in the adder when reset hit.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.adder_we   <= 1'b0;
      bus.adder_args <= '0;
      launch_id      <= '0;
      bus.resp_valid <= '0;
      bus.resp_sum   <= '0;
      bus.err        <= 1'b0;
      outst          <= '0;
      mask_cnt       <= CNT_W'(LAT + 1);
    end else begin
      bus.adder_we <= xfer;
      if (xfer) begin
        bus.adder_args <= win_args;
        launch_id      <= win;
      end
      bus.resp_valid <= ret ? (N_REQ'(1) << tag_id) : '0;
      if (ret) bus.resp_sum <= bus.adder_sum;
      if (mask_cnt != '0) begin
        mask_cnt <= mask_cnt - 1'b1;
      end else if (bus.adder_valid != tag_vld) begin
        bus.err <= 1'b1;
      end
      case ({xfer, ret})
        2'b10:   outst <= outst + 1'b1;
        2'b01:   outst <= outst - 1'b1;
        default: outst <= outst;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_RUN;
      bus.drained <= 1'b0;
    end else begin
      unique case (state)
        ST_RUN: begin
          if (bus.drain_req) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!bus.drain_req) begin
            state <= ST_RUN;
          end else if (outst == '0 && !ret) begin
            state       <= ST_DRAINED;
            bus.drained <= 1'b1;
          end
        end
        ST_DRAINED: begin
          if (!bus.drain_req) begin
            state       <= ST_RUN;
            bus.drained <= 1'b0;
          end
        end
        default: begin
          state       <= ST_RUN;
          bus.drained <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_piped_adder_arb.sv
// Directed bench for piped_adder_arb with a behavioural 3-stage adder (N_args=8).
module tb_piped_adder_arb;
  localparam int LAT   = 3;
  localparam int TOTAL = LAT + 2;

  typedef struct {
    int         id;
    int         first;
    int         step;
    int         exp_sum;
    logic [3:0] exp_rv;
  } vec_t;

  typedef struct {
    int          at;
    logic [3:0]  rv;
    logic [14:0] sum;
  } resp_t;

  logic clk    = 1'b0;
  logic reset  = 1'b1;
  logic inject = 1'b0;
  int   cyc    = 0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   c;
  int   exp_k [4];
  vec_t vecs [4];
  resp_t rq [$];

  piped_adder_arb_if #(.N_REQ(4), .N_args(8), .arg_width(12)) bus ();

  piped_adder_arb #(.N_REQ(4), .N_args(8), .arg_width(12)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in for the external piped_adder: LAT clocks from we to valid, never reset.
  logic [LAT-1:0] am_v = '0;
  logic [14:0]    am_s [LAT];
  always @(posedge clk) begin
    logic [14:0] s;
    s = '0;
    for (int j = 0; j < 8; j++) s = s + 15'(bus.adder_args[j*12 +: 12]);
    am_v <= {am_v[LAT-2:0], bus.adder_we};
    am_s[0] <= s;
    for (int i = 1; i < LAT; i++) am_s[i] <= am_s[i-1];
  end
  assign bus.adder_valid = am_v[LAT-1] | inject;
  assign bus.adder_sum   = am_s[LAT-1];

  always @(negedge clk) begin
    if (!reset && bus.resp_valid != '0) begin
      resp_t r;
      r.at  = cyc;
      r.rv  = bus.resp_valid;
      r.sum = bus.resp_sum;
      rq.push_back(r);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_args(input int k, input int first, input int step);
    for (int j = 0; j < 8; j++) bus.req_args[(k*8 + j)*12 +: 12] = 12'(first + j*step);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.req_valid = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{id: 2, first: 1,    step: 1,   exp_sum: 36,    exp_rv: 4'b0100};
    vecs[1] = '{id: 0, first: 0,    step: 0,   exp_sum: 0,     exp_rv: 4'b0001};
    vecs[2] = '{id: 3, first: 4095, step: 0,   exp_sum: 32760, exp_rv: 4'b1000};
    vecs[3] = '{id: 1, first: 100,  step: 100, exp_sum: 3600,  exp_rv: 4'b0010};
    exp_k = '{8, 16, 24, 32};

    // Reset state, with a request pending during reset.
    bus.req_args  = '0;
    bus.drain_req = 1'b0;
    bus.req_valid = 4'b0001;
    repeat (2) @(negedge clk);
    #1 check("ready in reset", 32'(bus.req_ready), 32'd0);
    reset = 1'b0;
    bus.req_valid = '0;
    @(negedge clk);
    check("rst adder_we",   32'(bus.adder_we),   32'd0);
    check("rst adder_args", 32'(bus.adder_args[31:0]), 32'd0);
    check("rst resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst resp_sum",   32'(bus.resp_sum),   32'd0);
    check("rst drained",    32'(bus.drained),    32'd0);
    check("rst err",        32'(bus.err),        32'd0);
    check("rst outst",      32'(dut.outst),      32'd0);

    // Single requests: sum, one-hot owner and LAT+2 latency.
    for (int v = 0; v < 4; v++) begin
      rq.delete();
      @(negedge clk);
      set_args(vecs[v].id, vecs[v].first, vecs[v].step);
      bus.req_valid = 4'b0001 << vecs[v].id;
      c = cyc;
      #1 check($sformatf("vec%0d grant", v), 32'(bus.req_ready), 32'(vecs[v].exp_rv));
      @(negedge clk);
      bus.req_valid = '0;
      for (int k = 0; k < 20 && rq.size() == 0; k++) @(posedge clk);
      check($sformatf("vec%0d resp count", v), 32'(rq.size()), 32'd1);
      if (rq.size() > 0) begin
        check($sformatf("vec%0d resp_valid", v), 32'(rq[0].rv), 32'(vecs[v].exp_rv));
        check($sformatf("vec%0d resp_sum", v), 32'(rq[0].sum), 32'(vecs[v].exp_sum));
        check($sformatf("vec%0d latency", v), 32'(rq[0].at - c), 32'(TOTAL));
      end
    end
    check("err after singles", 32'(bus.err), 32'd0);

    do_reset();
    for (int k = 0; k < 4; k++) set_args(k, k + 1, 0);
    rq.delete();

`ifdef PIPED_ADDER_ARB_RR_EN
    @(negedge clk);
    c = cyc;
    bus.req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      #1 check($sformatf("rr grant %0d", i), 32'(bus.req_ready), 32'(4'b0001 << (i % 4)));
      @(negedge clk);
    end
    bus.req_valid = '0;
    repeat (10) @(posedge clk);
    check("rr resp count", 32'(rq.size()), 32'd8);
    for (int i = 0; i < 8 && i < rq.size(); i++) begin
      check($sformatf("rr resp_valid %0d", i), 32'(rq[i].rv), 32'(4'b0001 << (i % 4)));
      check($sformatf("rr resp_sum %0d", i), 32'(rq[i].sum), 32'(exp_k[i % 4]));
      check($sformatf("rr resp cycle %0d", i), 32'(rq[i].at - c), 32'(TOTAL + i));
    end
`else
    @(negedge clk);
    c = cyc;
    bus.req_valid = 4'b1010;
    for (int i = 0; i < 8; i++) begin
      #1 check($sformatf("fp grant %0d", i), 32'(bus.req_ready), 32'(4'b0010));
      @(negedge clk);
    end
    bus.req_valid = 4'b1000;
    #1 check("fp req3 after release", 32'(bus.req_ready), 32'(4'b1000));
    @(negedge clk);
    bus.req_valid = '0;
    repeat (10) @(posedge clk);
    check("fp resp count", 32'(rq.size()), 32'd9);
    for (int i = 0; i < 9 && i < rq.size(); i++) begin
      check($sformatf("fp resp_valid %0d", i), 32'(rq[i].rv), 32'((i < 8) ? 4'b0010 : 4'b1000));
      check($sformatf("fp resp_sum %0d", i), 32'(rq[i].sum), 32'((i < 8) ? 16 : 32));
      check($sformatf("fp resp cycle %0d", i), 32'(rq[i].at - c), 32'(TOTAL + i));
    end
`endif

    // Drain with three sums in flight; the third is granted as drain_req rises.
    rq.delete();
    @(negedge clk);
    c = cyc;
    bus.req_valid = 4'b0001;
    @(negedge clk);
    bus.req_valid = 4'b0010;
    @(negedge clk);
    bus.req_valid = 4'b0100;
    bus.drain_req = 1'b1;
    #1 check("drain same-cycle grant", 32'(bus.req_ready), 32'(4'b0100));
    @(negedge clk);
    bus.req_valid = 4'b1000;
    #1 check("drain ready low", 32'(bus.req_ready), 32'd0);
    repeat (4) @(negedge clk);
    #1 check("drain outst zero", 32'(dut.outst), 32'd0);
    check("drained not yet", 32'(bus.drained), 32'd0);
    @(negedge clk);
    #1 check("drained set", 32'(bus.drained), 32'd1);
    check("drained ready low", 32'(bus.req_ready), 32'd0);
    check("drain resp count", 32'(rq.size()), 32'd3);
    for (int i = 0; i < 3 && i < rq.size(); i++) begin
      check($sformatf("drain resp_valid %0d", i), 32'(rq[i].rv), 32'(4'b0001 << i));
      check($sformatf("drain resp_sum %0d", i), 32'(rq[i].sum), 32'(exp_k[i]));
      check($sformatf("drain resp cycle %0d", i), 32'(rq[i].at - c), 32'(TOTAL + i));
    end
    bus.drain_req = 1'b0;
    @(negedge clk);
    #1 check("resume grant", 32'(bus.req_ready), 32'(4'b1000));
    check("resume drained low", 32'(bus.drained), 32'd0);
    @(posedge clk);
    #1 bus.req_valid = '0;
    repeat (8) @(posedge clk);
    check("resume resp count", 32'(rq.size()), 32'd4);
    if (rq.size() > 3) begin
      check("resume resp_valid", 32'(rq[3].rv), 32'(4'b1000));
      check("resume resp_sum", 32'(rq[3].sum), 32'd32);
    end

    // Spurious adder_valid with no tag in flight.
    @(negedge clk);
    check("err clear before inject", 32'(bus.err), 32'd0);
    inject = 1'b1;
    @(negedge clk);
    inject = 1'b0;
    check("err set", 32'(bus.err), 32'd1);
    repeat (5) @(negedge clk);
    check("err sticky", 32'(bus.err), 32'd1);
    do_reset();
    @(negedge clk);
    check("err cleared by reset", 32'(bus.err), 32'd0);

    // Reset with two sums in flight: their late adder_valid pulses must be ignored.
    rq.delete();
    @(negedge clk);
    bus.req_valid = 4'b0001;
    @(negedge clk);
    bus.req_valid = 4'b0010;
    @(negedge clk);
    bus.req_valid = 4'b0100;
    reset = 1'b1;
    #1 check("ready low in mid reset", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    bus.req_valid = '0;
    repeat (10) @(negedge clk);
    check("mid reset no resp", 32'(rq.size()), 32'd0);
    check("mid reset err", 32'(bus.err), 32'd0);
    check("mid reset outst", 32'(dut.outst), 32'd0);
    check("mid reset drained", 32'(bus.drained), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
